// File: rtl/midi_note_decoder_pkg.sv
// rtl/midi_note_decoder_pkg.sv - shared constants, FSM state and byte-class types for the MIDI note decoder
package synth_midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [3:0] {
    WAIT_STATUS = 4'b0001,
    DATA1       = 4'b0010,
    DATA2       = 4'b0100,
    SYSEX       = 4'b1000
  } midi_state_e;

  typedef enum logic [1:0] {
    BYTE_DATA,
    BYTE_CHANNEL,
    BYTE_SYSTEM,
    BYTE_REALTIME
  } byte_class_e;

  // Program change and channel pressure carry one data byte; every other channel message carries two.
  function automatic logic [1:0] data_bytes(input logic [3:0] kind);
    return (kind == PROG || kind == CHPRESS) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_note_decoder_if.sv
// rtl/midi_note_decoder_if.sv - byte stream in, note events out, between UART, decoder and envelope generator
interface midi_note_decoder_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       note_on;
  logic       note_off;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       gate;
  logic       err;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, note_on, note_off, note, velocity, gate, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, note_on, note_off, note, velocity, gate, err
  );

endinterface

// File: rtl/midi_note_decoder_status_decode.sv
// rtl/midi_note_decoder_status_decode.sv - combinational classifier for one incoming MIDI byte
module midi_status_decode
  import synth_midi_pkg::*;
#(
  parameter int unsigned CHANNEL = 0,
  parameter bit          OMNI    = 1'b0
) (
  input  logic [7:0]  byte_i,
  output byte_class_e byte_class_o,
  output logic        eox_o,
  output logic [1:0]  data_count_o,
  output logic        ch_match_o
);

  localparam logic [3:0] CH = 4'(CHANNEL);

  always_comb begin
    byte_class_o = BYTE_DATA;
    if (byte_i[7]) begin
      if (byte_i[7:3] == 5'b11111) begin
        byte_class_o = BYTE_REALTIME;
      end else if (byte_i[7:4] == 4'hF) begin
        byte_class_o = BYTE_SYSTEM;
      end else begin
        byte_class_o = BYTE_CHANNEL;
      end
    end
  end

  // End-of-exclusive closes a sysex dump, so data after it has no running status again.
  assign eox_o        = (byte_i == 8'hF7);
  assign data_count_o = data_bytes(byte_i[7:4]);
  assign ch_match_o   = OMNI || (byte_i[3:0] == CH);

endmodule

// File: rtl/midi_note_decoder.sv
// rtl/midi_note_decoder.sv - monophonic MIDI channel-voice parser producing note_on/note_off pulses and gate
module midi_note_decoder
  import synth_midi_pkg::*;
#(
  parameter int unsigned CHANNEL = 0,
  parameter bit          OMNI    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_b,
  midi_note_decoder_if.slave midi_if
);

  byte_class_e byte_class;
  logic        byte_eox;
  logic [1:0]  byte_data_count;
  logic        byte_ch_match;

  midi_status_decode #(
    .CHANNEL(CHANNEL),
    .OMNI   (OMNI)
  ) u_status_decode (
    .byte_i      (midi_if.rx_data),
    .byte_class_o(byte_class),
    .eox_o       (byte_eox),
    .data_count_o(byte_data_count),
    .ch_match_o  (byte_ch_match)
  );

  midi_state_e state_q;
  logic [3:0]  rs_kind_q;
  logic        rs_skip_q;
  logic        rs_two_q;
  logic [6:0]  d1_q;
  logic        rx_ready_q;
  logic        note_on_q;
  logic        note_off_q;
  logic [6:0]  note_q;
  logic [6:0]  velocity_q;
  logic        gate_q;
  logic        err_q;

  logic       accept;
  logic       data_byte;
  logic       msg_done;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;
  logic       act_on;
  logic       act_off;
  logic       act_all_off;

  // A message completes on its last data byte; the running status lives only in DATA1/DATA2.
  always_comb begin
    accept    = midi_if.rx_valid && rx_ready_q;
    data_byte = (byte_class == BYTE_DATA);
    msg_done  = accept && data_byte &&
                ((state_q == DATA1 && !rs_two_q) || (state_q == DATA2));
    msg_d1    = (state_q == DATA2) ? d1_q : midi_if.rx_data[6:0];
    msg_d2    = (state_q == DATA2) ? midi_if.rx_data[6:0] : 7'd0;

    act_on      = msg_done && !rs_skip_q && rs_kind_q == NOTE_ON && msg_d2 != 7'd0;
    act_off     = msg_done && !rs_skip_q && gate_q && msg_d1 == note_q &&
                  (rs_kind_q == NOTE_OFF || (rs_kind_q == NOTE_ON && msg_d2 == 7'd0));
    act_all_off = msg_done && !rs_skip_q && gate_q &&
                  rs_kind_q == CTRL && msg_d1 == CC_ALL_NOTES_OFF;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= WAIT_STATUS;
      rs_kind_q  <= 4'h0;
      rs_skip_q  <= 1'b0;
      rs_two_q   <= 1'b0;
      d1_q       <= 7'd0;
      rx_ready_q <= 1'b0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      note_q     <= 7'd0;
      velocity_q <= 7'd0;
      gate_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_ready_q <= 1'b1;
      note_on_q  <= act_on;
      note_off_q <= act_off || act_all_off;
      err_q      <= accept && data_byte && state_q == WAIT_STATUS;

      if (act_on) begin
        note_q     <= msg_d1;
        velocity_q <= msg_d2;
        gate_q     <= 1'b1;
      end else if (act_off || act_all_off) begin
        gate_q <= 1'b0;
      end

      if (accept) begin
        case (byte_class)
          BYTE_CHANNEL: begin
            rs_kind_q <= midi_if.rx_data[7:4];
            rs_skip_q <= !byte_ch_match;
            rs_two_q  <= (byte_data_count == 2'd2);
            state_q   <= DATA1;
          end
          BYTE_SYSTEM: begin
            rs_skip_q <= 1'b0;
            state_q   <= byte_eox ? WAIT_STATUS : SYSEX;
          end
          BYTE_DATA: begin
            case (state_q)
              DATA1: begin
                d1_q    <= midi_if.rx_data[6:0];
                state_q <= rs_two_q ? DATA2 : DATA1;
              end
              DATA2:   state_q <= DATA1;
              default: state_q <= state_q;
            endcase
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign midi_if.rx_ready = rx_ready_q;
  assign midi_if.note_on  = note_on_q;
  assign midi_if.note_off = note_off_q;
  assign midi_if.note     = note_q;
  assign midi_if.velocity = velocity_q;
  assign midi_if.gate     = gate_q;
  assign midi_if.err      = err_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// tb/tb_midi_note_decoder.sv - directed scenarios plus randomized byte stream against a message-level model
module tb_midi_note_decoder;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  midi_note_decoder_if mif ();

  midi_note_decoder #(
    .CHANNEL(0),
    .OMNI   (1'b0)
  ) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .midi_if(mif)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Message-level reference: running status byte, collected data bytes, sysex flag.
  int rs = -1;
  bit sysex = 0;
  int q[$];
  bit e_ready = 0, e_on = 0, e_off = 0, e_err = 0, e_gate = 0;
  int e_note = 0, e_vel = 0;
  bit acc;

  task automatic model_clear();
    rs = -1; sysex = 0; q.delete();
    e_ready = 0; e_on = 0; e_off = 0; e_err = 0; e_gate = 0; e_note = 0; e_vel = 0;
  endtask

  task automatic model_act(input int kind, input int d1, input int d2);
    if (kind == 9 && d2 != 0) begin
      e_on = 1; e_note = d1; e_vel = d2; e_gate = 1;
    end else if ((kind == 8 || kind == 9) && e_gate && d1 == e_note) begin
      e_off = 1; e_gate = 0;
    end else if (kind == 11 && d1 == 123 && e_gate) begin
      e_off = 1; e_gate = 0;
    end
  endtask

  task automatic model_byte(input int b);
    int need;
    if (b >= 8'hF8) begin
    end else if (b == 8'hF7) begin
      rs = -1; sysex = 0; q.delete();
    end else if (b >= 8'hF0) begin
      rs = -1; sysex = 1; q.delete();
    end else if (b >= 8'h80) begin
      rs = b; sysex = 0; q.delete();
    end else if (sysex) begin
    end else if (rs < 0) begin
      e_err = 1;
    end else begin
      q.push_back(b);
      need = ((rs >> 4) == 12 || (rs >> 4) == 13) ? 1 : 2;
      if (q.size() == need) begin
        if ((rs & 15) == 0) model_act(rs >> 4, q[0], need == 2 ? q[1] : 0);
        q.delete();
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_b) begin
      model_clear();
    end else begin
      acc = mif.rx_valid && e_ready;
      e_on = 0; e_off = 0; e_err = 0;
      e_ready = 1;
      if (acc) model_byte(int'(mif.rx_data));
    end
  end

  always @(negedge rst_b) model_clear();

  always @(negedge clk) begin
    chk("rx_ready", mif.rx_ready, e_ready);
    chk("note_on", mif.note_on, e_on);
    chk("note_off", mif.note_off, e_off);
    chk("err", mif.err, e_err);
    chk("gate", mif.gate, e_gate);
    chk("note", mif.note, e_note);
    chk("velocity", mif.velocity, e_vel);
  end

  int on_cnt = 0, off_cnt = 0, err_cnt = 0;
  always @(negedge clk) begin
    on_cnt  += mif.note_on;
    off_cnt += mif.note_off;
    err_cnt += mif.err;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    mif.rx_data  = b;
    mif.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    mif.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    idle(1);
    on_cnt = 0; off_cnt = 0; err_cnt = 0;
  endtask

  task automatic chk_zero(input string name);
    chk(name, int'({mif.rx_ready, mif.note_on, mif.note_off, mif.gate, mif.err, mif.note, mif.velocity}), 0);
  endtask

  // Reset entered just after an edge; released on a falling edge with a byte already offered,
  // which must not be taken since rx_ready is still low at the next edge.
  task automatic pulse_reset(input int n);
    rst_b = 1'b0;
    #1;
    chk_zero("reset_outputs");
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_b        = 1'b1;
    mif.rx_data  = 8'h3C;
    mif.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    mif.rx_valid = 1'b0;
    chk("ready_after_release", mif.rx_ready, 1);
  endtask

  logic [7:0] status_tbl [12] = '{8'h80, 8'h90, 8'h91, 8'hB0, 8'hC0, 8'hD0,
                                  8'hE0, 8'hF0, 8'hF7, 8'hF8, 8'hFE, 8'hF2};

  initial begin
    mif.rx_data  = 8'h00;
    mif.rx_valid = 1'b0;
    #1 rst_b = 1'b0;
    #1 chk_zero("init_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk("init_ready", mif.rx_ready, 1);

    send(8'h90); send(8'h3C); send(8'h64);
    chk("t1_note_on", mif.note_on, 1);
    chk("t1_note", mif.note, 60);
    chk("t1_velocity", mif.velocity, 100);
    chk("t1_gate", mif.gate, 1);

    send(8'h3E); send(8'h50);
    chk("t2_note_on", mif.note_on, 1);
    chk("t2_note", mif.note, 62);
    send(8'h3E); send(8'h00);
    chk("t2_note_off", mif.note_off, 1);
    chk("t2_gate", mif.gate, 0);
    chk("t2_velocity", mif.velocity, 80);

    send(8'h90); send(8'h3C); send(8'h64);
    clr();
    send(8'h80); send(8'h40); send(8'h40);
    idle(1);
    chk("t3_no_off", off_cnt, 0);
    chk("t3_gate_held", mif.gate, 1);
    send(8'h80); send(8'h3C); send(8'h00);
    chk("t3_note_off", mif.note_off, 1);
    chk("t3_gate", mif.gate, 0);

    clr();
    send(8'h91); send(8'h3C); send(8'h64);
    idle(1);
    chk("t4_skip_on", on_cnt, 0);
    chk("t4_skip_err", err_cnt, 0);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    chk("t4_rt_note_on", mif.note_on, 1);
    chk("t4_rt_note", mif.note, 60);
    send(8'hB0); send(8'h7B); send(8'h00);
    chk("t4_all_off", mif.note_off, 1);
    chk("t4_all_off_gate", mif.gate, 0);

    clr();
    send(8'hF0); send(8'h3C); send(8'h64); send(8'hF7);
    idle(1);
    chk("t5_sysex_on", on_cnt, 0);
    chk("t5_sysex_err", err_cnt, 0);
    send(8'h3C); send(8'h64);
    idle(1);
    chk("t5_err_count", err_cnt, 2);
    chk("t5_no_on", on_cnt, 0);

    clr();
    send(8'h90); send(8'h3C);
    pulse_reset(2);
    send(8'h64);
    idle(1);
    chk("t6_err_count", err_cnt, 1);
    chk("t6_no_on", on_cnt, 0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      int k;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset(2);
      end else if (r < 8) begin
        idle(1);
      end else if (r < 24) begin
        send(status_tbl[$urandom_range(0, 11)]);
      end else begin
        k = $urandom_range(0, 9);
        if (k < 6)       send(8'(60 + (k % 4)));
        else if (k == 6) send(8'h00);
        else if (k == 7) send(8'h7B);
        else             send(8'($urandom_range(0, 127)));
      end
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
